i2s_tx_framer: RTL and testbench

Parametrised stereo I2S/LJ/RJ serial audio transmitter.
- Generates its own BCLK/WCLK from clk_in by an integer divider.
- Accepts samples through a valid/ready handshake with a one-entry holding register.
- Serialises samples in a runtime-selectable format, with mute, enable and underrun reporting.
- Sits between the audio mixer/sample source and the external DAC pins.

---
 rtl/i2s_tx_framer.sv | 147 ++++++++++++++
 tb/tb_i2s_tx_framer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_framer.sv
// Stereo I2S / left-justified / right-justified serial transmitter with internal
// BCLK/WCLK divider and a one-entry sample holding register.
module i2s_tx_framer #(
  parameter int BITS      = 24,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 8
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      fmt,
  input  logic            mute,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_left,
  input  logic [BITS-1:0] s_right,
  output logic            sample_pulse,
  output logic            underrun,
  output logic            I2S_BCLK,
  output logic            I2S_WCLK,
  output logic            I2S_DATA
);

  if (BITS < 8 || BITS > 32) begin : g_bad_bits
    $error("i2s_tx_framer: BITS must be 8..32");
  end
  if (SLOT_BITS < 16 || SLOT_BITS > 32 || SLOT_BITS < BITS) begin : g_bad_slot
    $error("i2s_tx_framer: SLOT_BITS must be 16..32 and >= BITS");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("i2s_tx_framer: CLK_DIV must be even and >= 2");
  end

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);
  localparam logic [6:0]    FRAME_LAST = 7'(2 * SLOT_BITS - 1);
  localparam logic [6:0]    SLOT       = 7'(SLOT_BITS);
  localparam logic [6:0]    RJ_OFF     = 7'(SLOT_BITS - BITS);
  localparam logic [6:0]    BITS7      = 7'(BITS);

  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [6:0]      bit_cnt_q, bit_cnt_d;
  logic            pending_q, pending_d;
  logic [BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [BITS-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic [1:0]      fmt_q, fmt_d;
  logic            bclk_q, wclk_q, data_q, pulse_q, urun_q;

  logic            tick, frame_start, accept, slot_r, data_bit;
  logic [6:0]      k, off, rel;
  logic [BITS-1:0] sample, shifted;

  always_comb begin
    tick        = enable && (div_cnt_q == DIV_LAST);
    frame_start = tick && (bit_cnt_q == FRAME_LAST);
    accept      = s_valid && !pending_q;

    if (!enable)   div_cnt_d = DIV_LAST;
    else if (tick) div_cnt_d = '0;
    else           div_cnt_d = div_cnt_q + DIV_ONE;

    if (!enable)          bit_cnt_d = FRAME_LAST;
    else if (frame_start) bit_cnt_d = '0;
    else if (tick)        bit_cnt_d = bit_cnt_q + 7'd1;
    else                  bit_cnt_d = bit_cnt_q;

    pending_d = pending_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    if (accept) begin
      pending_d = 1'b1;
      hold_l_d  = s_left;
      hold_r_d  = s_right;
    end else if (frame_start) begin
      pending_d = 1'b0;
    end

    fmt_d     = frame_start ? fmt : fmt_q;
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    if (frame_start) begin
      frame_l_d = (pending_q && !mute) ? hold_l_q : '0;
      frame_r_d = (pending_q && !mute) ? hold_r_q : '0;
    end

    // Data for the bit that starts on this tick is derived from the next-state
    // frame/format so the first bit of a new frame already uses the fresh sample.
    slot_r = (bit_cnt_d >= SLOT);
    k      = slot_r ? (bit_cnt_d - SLOT) : bit_cnt_d;
    case (fmt_d)
      2'd1:    off = 7'd0;
      2'd2:    off = RJ_OFF;
      default: off = 7'd1;
    endcase
    rel      = k - off;
    sample   = slot_r ? frame_r_d : frame_l_d;
    shifted  = sample << rel;
    data_bit = (k >= off) && (rel < BITS7) && shifted[BITS-1];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q <= DIV_LAST;
      bit_cnt_q <= FRAME_LAST;
      pending_q <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      frame_l_q <= '0;
      frame_r_q <= '0;
      fmt_q     <= 2'd0;
      bclk_q    <= 1'b0;
      wclk_q    <= 1'b0;
      data_q    <= 1'b0;
      pulse_q   <= 1'b0;
      urun_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
      fmt_q     <= fmt_d;
      bclk_q    <= enable && (div_cnt_d >= DIV_HALF);
      pulse_q   <= frame_start;
      urun_q    <= frame_start && !pending_q;
      if (!enable) begin
        wclk_q <= 1'b0;
        data_q <= 1'b0;
      end else if (tick) begin
        wclk_q <= slot_r;
        data_q <= data_bit;
      end
    end
  end

  assign s_ready      = !pending_q;
  assign sample_pulse = pulse_q;
  assign underrun     = urun_q;
  assign I2S_BCLK     = bclk_q;
  assign I2S_WCLK     = wclk_q;
  assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Directed bench for i2s_tx_framer (BITS=16, SLOT_BITS=32, CLK_DIV=4); serial
// frames are captured MSB-first into 64-bit vectors and compared to constants.
module tb_i2s_tx_framer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  fmt = 2'd0;
  logic        mute = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic        sample_pulse, underrun, I2S_BCLK, I2S_WCLK, I2S_DATA;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic        src_en = 1'b0;
  logic [15:0] cnt = '0;

  localparam logic [63:0] WCLK_EXP = {32'h0, 32'hFFFF_FFFF};

  i2s_tx_framer #(.BITS(16), .SLOT_BITS(32), .CLK_DIV(4)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .fmt(fmt), .mute(mute),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .sample_pulse(sample_pulse), .underrun(underrun),
    .I2S_BCLK(I2S_BCLK), .I2S_WCLK(I2S_WCLK), .I2S_DATA(I2S_DATA)
  );

  initial forever #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; when the streaming source is active, move to the next
  // value after each accepted handshake.
  task automatic step();
    logic acc;
    acc = s_valid && s_ready;
    @(negedge clk_in);
    if (src_en && acc) begin
      cnt     = cnt + 16'd1;
      s_left  = cnt;
      s_right = ~cnt;
    end
  endtask

  function automatic logic [63:0] i2s_exp(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  task automatic capture(output logic [63:0] dv, output logic [63:0] wv,
                         output logic [7:0] bv, output int ucnt,
                         output logic u0, output logic r0, output logic r1);
    int n;
    n = 0;
    while (sample_pulse !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    chk("frame_start_seen", 64'(sample_pulse), 64'd1);
    dv = '0; wv = '0; bv = '0; ucnt = 0; r1 = 1'b0;
    u0 = underrun;
    r0 = s_ready;
    for (int c = 0; c < 256; c++) begin
      if (c % 4 == 0) begin
        dv = {dv[62:0], I2S_DATA};
        wv = {wv[62:0], I2S_WCLK};
      end
      if (c < 8) bv = {bv[6:0], I2S_BCLK};
      if (c == 1) r1 = s_ready;
      if (underrun) ucnt++;
      step();
    end
  endtask

  logic [63:0] dv, wv;
  logic [7:0]  bv;
  int          ucnt;
  logic        u0, r0, r1, bad;

  initial begin
    // Reset and idle
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_outputs", 64'({I2S_BCLK, I2S_WCLK, I2S_DATA, sample_pulse, underrun}), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (I2S_BCLK || I2S_WCLK || I2S_DATA || sample_pulse || underrun) bad = 1'b1;
      step();
    end
    chk("idle_quiet", 64'(bad), 64'd0);

    // Pre-load A5C3/8001, then enable in I2S format
    s_left = 16'hA5C3; s_right = 16'h8001; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("preload_ready_low", 64'(s_ready), 64'd0);
    fmt = 2'd0; enable = 1'b1;
    step();
    chk("first_cycle_pulse", 64'(sample_pulse), 64'd1);
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("i2s_data", dv, 64'h52E1_8000_4000_8000);
    chk("i2s_wclk", wv, WCLK_EXP);
    chk("i2s_bclk", 64'(bv), 64'h33);
    chk("i2s_no_underrun", 64'(ucnt), 64'd0);

    // Underrun: no further samples
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("urun2_data", dv, 64'd0);
    chk("urun2_at_pulse", 64'(u0), 64'd1);
    chk("urun2_count", 64'(ucnt), 64'd1);
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("urun3_data", dv, 64'd0);
    chk("urun3_at_pulse", 64'(u0), 64'd1);
    chk("urun3_count", 64'(ucnt), 64'd1);

    // Disable, then LJ frame with a mid-frame switch to RJ
    enable = 1'b0;
    step();
    chk("disable_outputs", 64'({I2S_BCLK, I2S_WCLK, I2S_DATA}), 64'd0);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    fmt = 2'd1; enable = 1'b1;
    step();
    s_valid = 1'b1; fmt = 2'd2;
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("lj_data", dv, 64'hA5C3_0000_8001_0000);
    chk("lj_wclk", wv, WCLK_EXP);
    s_valid = 1'b0;
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("rj_data", dv, 64'h0000_A5C3_0000_8001);

    // Back-to-back streaming, 8 frames
    enable = 1'b0; fmt = 2'd0;
    step();
    src_en = 1'b1; cnt = 16'h0100; s_left = cnt; s_right = ~cnt; s_valid = 1'b1;
    step();
    enable = 1'b1;
    step();
    for (int f = 0; f < 8; f++) begin
      capture(dv, wv, bv, ucnt, u0, r0, r1);
      chk($sformatf("stream%0d_data", f), dv,
          i2s_exp(16'h0100 + 16'(f), ~(16'h0100 + 16'(f))));
      chk($sformatf("stream%0d_urun", f), 64'(ucnt), 64'd0);
      chk($sformatf("stream%0d_ready", f), 64'({r0, r1}), 64'b10);
    end

    // Mute: raised mid-frame 9, applied at frame 10 start
    src_en = 1'b0; mute = 1'b1;
    s_left = 16'h7E81; s_right = 16'h0FF0; s_valid = 1'b1;
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("premute_data", dv, i2s_exp(16'h0108, 16'hFEF7));
    s_valid = 1'b0; mute = 1'b0;
    chk("mute_ready_consumed", 64'(s_ready), 64'd1);
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("mute_data", dv, 64'd0);
    chk("mute_no_underrun", 64'(u0), 64'd0);
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("postmute_underrun", 64'(u0), 64'd1);

    // Reset at bit_cnt = 20 with a sample pending
    s_left = 16'h3C3C; s_right = 16'hC3C3; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 79; i++) step();
    chk("prereset_pending", 64'(s_ready), 64'd0);
    reset = 1'b1; enable = 1'b0;
    step();
    chk("midreset_outputs", 64'({I2S_BCLK, I2S_WCLK, I2S_DATA, sample_pulse, underrun}), 64'd0);
    chk("midreset_discard", 64'(s_ready), 64'd1);
    reset = 1'b0;
    step();
    s_left = 16'h1234; s_right = 16'hFEDC; s_valid = 1'b1;
    step();
    s_valid = 1'b0; enable = 1'b1;
    step();
    chk("restart_pulse", 64'(sample_pulse), 64'd1);
    capture(dv, wv, bv, ucnt, u0, r0, r1);
    chk("restart_data", dv, i2s_exp(16'h1234, 16'hFEDC));
    chk("restart_wclk", wv, WCLK_EXP);
    chk("restart_no_underrun", 64'(u0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
